// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
// Read-side drain controller for a single-clock synchronous FIFO. It issues
// read strobes, captures the FIFO's registered read data one cycle later and
// presents the words downstream on a valid/ready stream through a 2-entry
// skid buffer. It sustains one word per clock while the FIFO is non-empty
// and the consumer is ready.
//
// Optional build macro: FIFO_RD_CNT_EN adds the rd_count output, a 16-bit
// wrapping count of delivered words.
//
// Ports:
//   clk_single_domain  sole clock, rising edge
//   rst                synchronous active-low reset
//   en                 drain enable (1 = fetch, 0 = stop issuing reads)
//   fifo_empty         FIFO empty flag
//   fifo_ren           FIFO read strobe (combinational)
//   fifo_rdata         FIFO read data, valid when fifo_rvalid=1
//   fifo_rvalid        FIFO read data valid, one cycle after fifo_ren
//   to_the_user        head-of-buffer data
//   out_valid          to_the_user holds a valid word
//   out_ready          consumer accepts the word this cycle
//   busy               controller is not idle
//   proto_err          sticky: read data arrived with no read outstanding
//   rd_count           (FIFO_RD_CNT_EN only) delivered-word count
module sync_fifo_reader #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clk_single_domain,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rvalid,
  output logic [DATA_W-1:0] to_the_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              proto_err
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic              inflight;
  logic [DATA_W-1:0] tail_q;
  logic              pop;
  logic              capture;
  logic [2:0]        credit;

  assign out_valid = (cnt != 2'd0);
  assign busy      = (state != IDLE);
  assign pop       = out_valid & out_ready;
  assign capture   = fifo_rvalid & inflight;

  // Words that will occupy the skid buffer once everything outstanding lands;
  // a pop in this same cycle frees a slot, which keeps the stream at full rate.
  assign credit = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    fifo_ren = rst & (state == RUN) & ~fifo_empty & (credit < 3'(SKID_DEPTH));
  end

  // Control, head register and sticky error
  always_ff @(posedge clk_single_domain) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      inflight    <= 1'b0;
      proto_err   <= 1'b0;
      to_the_user <= '0;
    end else begin
      inflight <= fifo_ren;
      cnt      <= cnt + {1'b0, capture} - {1'b0, pop};

      if (fifo_rvalid && !inflight)
        proto_err <= 1'b1;

      // Head advances on a pop; a capture goes straight to the head when the
      // head slot is (or is about to become) empty, otherwise to the tail.
      if (pop) begin
        if (cnt == 2'd2)
          to_the_user <= tail_q;
        else if (capture)
          to_the_user <= fifo_rdata;
      end else if (capture && cnt == 2'd0) begin
        to_the_user <= fifo_rdata;
      end

      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= STOP;
        STOP: begin
          if (en)
            state <= RUN;
          else if (!inflight && cnt == 2'd0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Second skid entry: data only, meaningful while cnt == 2
  always_ff @(posedge clk_single_domain) begin
    if (capture && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop)))
      tail_q <= fifo_rdata;
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk_single_domain) begin
    if (!rst)
      rd_count <= 16'd0;
    else if (pop)
      rd_count <= rd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic       fifo_ren;
  logic [7:0] fifo_rdata;
  logic       fifo_rvalid;
  logic [7:0] to_the_user;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       proto_err;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem[$];
  logic [7:0] sb[$];

  logic       r, p, v;
  logic [7:0] d;

  always #5 clk = ~clk;

  sync_fifo_reader #(.DATA_W(8), .SKID_DEPTH(2)) dut (
    .clk_single_domain (clk),
    .rst               (rst),
    .en                (en),
    .fifo_empty        (fifo_empty),
    .fifo_ren          (fifo_ren),
    .fifo_rdata        (fifo_rdata),
    .fifo_rvalid       (fifo_rvalid),
    .to_the_user       (to_the_user),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .proto_err         (proto_err)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count          (rd_count)
`endif
  );

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of the FIFO model. Call at a negedge with inputs set; returns
  // pre-edge samples of the read strobe, pop, valid and head data. Each
  // served read pushes its word onto the scoreboard.
  task automatic tick(output logic ren_o, output logic pop_o,
                      output logic vld_o, output logic [7:0] dat_o);
    logic [7:0] served;
    served = 8'h00;
    #1;
    ren_o = fifo_ren;
    vld_o = out_valid;
    pop_o = out_valid & out_ready;
    dat_o = to_the_user;
    if (ren_o && mem.size() > 0) begin
      served = mem.pop_front();
      sb.push_back(served);
    end
    @(posedge clk);
    #1;
    fifo_rvalid = ren_o;
    fifo_rdata  = ren_o ? served : 8'h00;
    fifo_empty  = (mem.size() == 0);
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] w);
    mem.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rvalid = 1'b0; fifo_rdata = 8'h00;
    @(negedge clk);
    preload(8'h11); preload(8'h22); preload(8'h33);
    for (int i = 0; i < 3; i++) begin
      tick(r, p, v, d);
      checks++;
      if (r !== 1'b0 || v !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold ren=%b vld=%b busy=%b required 0 0 0", r, v, busy);
      end
    end
    checks++;
    if (to_the_user !== 8'h00 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals data=%h perr=%b required 00 0", to_the_user, proto_err);
    end
`ifdef FIFO_RD_CNT_EN
    checks++;
    if (rd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_rd_count got %0d required 0", rd_count);
    end
`endif
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(r, p, v, d);
      checks++;
      if (r !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_en_high ren=%b busy=%b required 0 0", r, busy);
      end
    end
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(r, p, v, d);
      checks++;
      if (r !== 1'b0 || v !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_en_low ren=%b vld=%b busy=%b required 0 0 0", r, v, busy);
      end
    end
  endtask

  task automatic test_stream;
    int first_ren, last_ren, ren_cnt, first_vld, npop, first_pop, last_pop;
    logic [7:0] got[$];
    logic [7:0] e;
    first_ren = -1; last_ren = -1; ren_cnt = 0; first_vld = -1;
    npop = 0; first_pop = -1; last_pop = -1;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(r, p, v, d);
      if (r) begin
        if (first_ren < 0) first_ren = i;
        last_ren = i;
        ren_cnt++;
      end
      if (v && first_vld < 0) first_vld = i;
      if (p) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        npop++;
        got.push_back(d);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (d !== e) begin
          errors++;
          $display("FAIL stream_sb got %h required %h", d, e);
        end
      end
    end
    checks++;
    if (ren_cnt != 3 || last_ren - first_ren != 2) begin
      errors++;
      $display("FAIL stream_reads count=%0d span=%0d required 3 2", ren_cnt, last_ren - first_ren);
    end
    checks++;
    if (first_vld - first_ren != 2) begin
      errors++;
      $display("FAIL stream_latency got %0d required 2", first_vld - first_ren);
    end
    checks++;
    if (npop != 3 || last_pop - first_pop != 2) begin
      errors++;
      $display("FAIL stream_pops count=%0d span=%0d required 3 2", npop, last_pop - first_pop);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      errors++;
      $display("FAIL stream_order got %p required 11 22 33", got);
    end
    en = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick(r, p, v, d);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure;
    int reads, npop;
    logic [7:0] exp_seq[3];
    logic [7:0] e;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    reads = 0; npop = 0;
    preload(8'h11); preload(8'h22); preload(8'h33);
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(r, p, v, d);
      if (r) reads++;
      if (v) begin
        checks++;
        if (d !== 8'h11) begin
          errors++;
          $display("FAIL bp_hold data=%h required 11", d);
        end
      end
    end
    checks++;
    if (reads != 2 || mem.size() != 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall reads=%0d left=%0d vld=%b required 2 1 1", reads, mem.size(), out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(r, p, v, d);
      if (p) begin
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (d !== e || (npop < 3 && d !== exp_seq[npop])) begin
          errors++;
          $display("FAIL bp_order got %h required %h", d, e);
        end
        npop++;
      end
    end
    checks++;
    if (npop != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count pops=%0d pending=%0d required 3 0", npop, sb.size());
    end
    en = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick(r, p, v, d);
  endtask

  task automatic test_en_drop;
    int reads, npop;
    logic [7:0] e;
    reads = 0; npop = 0;
    preload(8'h41); preload(8'h42); preload(8'h43); preload(8'h44);
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6 && reads == 0; i++) begin
      tick(r, p, v, d);
      if (r) reads++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(r, p, v, d);
      if (r) reads++;
      if (p) begin
        npop++;
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (d !== e) begin
          errors++;
          $display("FAIL endrop_data got %h required %h", d, e);
        end
      end
    end
    checks++;
    if (reads != 2 || npop != 2 || mem.size() != 2) begin
      errors++;
      $display("FAIL endrop_count reads=%0d pops=%0d left=%0d required 2 2 2", reads, npop, mem.size());
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL endrop_idle busy=%b vld=%b required 0 0", busy, out_valid);
    end
    mem.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_spurious;
    fifo_rvalid = 1'b1;
    fifo_rdata  = 8'hAA;
    @(posedge clk);
    #1;
    fifo_rvalid = 1'b0;
    fifo_rdata  = 8'h00;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1 || out_valid !== 1'b0 || to_the_user === 8'hAA) begin
      errors++;
      $display("FAIL spurious perr=%b vld=%b data=%h required 1 0 not-AA", proto_err, out_valid, to_the_user);
    end
    for (int i = 0; i < 3; i++) tick(r, p, v, d);
    checks++;
    if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_sticky perr=%b vld=%b required 1 0", proto_err, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    preload(8'h51); preload(8'h52); preload(8'h53);
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick(r, p, v, d);
    checks++;
    if (out_valid !== 1'b1 || to_the_user !== 8'h51) begin
      errors++;
      $display("FAIL midrst_pre vld=%b data=%h required 1 51", out_valid, to_the_user);
    end
    rst = 1'b0;
    mem.delete();
    sb.delete();
    fifo_empty = 1'b1;
    fifo_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0 ||
        to_the_user !== 8'h00 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL midrst vld=%b busy=%b perr=%b data=%h ren=%b required 0 0 0 00 0",
               out_valid, busy, proto_err, to_the_user, fifo_ren);
    end
`ifdef FIFO_RD_CNT_EN
    checks++;
    if (rd_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_rd_count got %0d required 0", rd_count);
    end
`endif
    rst = 1'b1;
    en = 1'b0;
    tick(r, p, v, d);
  endtask

`ifdef FIFO_RD_CNT_EN
  task automatic test_rd_count;
    int npop, bad;
    logic [7:0] e;
    npop = 0; bad = 0;
    for (int i = 0; i < 65538; i++) preload(8'(i));
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65600 && npop < 65538; i++) begin
      tick(r, p, v, d);
      if (p) begin
        npop++;
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (d !== e) bad++;
      end
    end
    checks++;
    if (bad != 0 || npop != 65538) begin
      errors++;
      $display("FAIL rdcnt_stream pops=%0d bad=%0d required 65538 0", npop, bad);
    end
    #1;
    checks++;
    if (rd_count !== 16'd2) begin
      errors++;
      $display("FAIL rdcnt_wrap got %0d required 2", rd_count);
    end
    en = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick(r, p, v, d);
    checks++;
    if (rd_count !== 16'd2) begin
      errors++;
      $display("FAIL rdcnt_hold got %0d required 2", rd_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_drop();
    test_spurious();
    test_reset_mid();
`ifdef FIFO_RD_CNT_EN
    test_rd_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_reader.md
Name: sync_fifo_reader

Overview:
- Read-side drain controller for the single-clock synchronous FIFO.
- Issues FIFO read strobes, captures the FIFO's registered read data, and delivers words downstream on a valid/ready stream through a 2-entry skid buffer.
- Sustains one word per clock when the FIFO is non-empty and downstream is ready.
- Sits between the FIFO read port and the user-side consumer.

Parameters:
- DATA_W, 8, width of FIFO words and output data.
- SKID_DEPTH, 2, skid buffer entries; fixed at 2, any other value is illegal.

Ports:
- clk_single_domain  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk_single_domain.
- en  input  1  drain enable; 1 = fetch from FIFO, 0 = stop issuing reads.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  FIFO read strobe (combinational).
- fifo_rdata  input  DATA_W  FIFO read data; valid in the cycle fifo_rvalid=1.
- fifo_rvalid  input  1  FIFO read-data valid; the FIFO returns data exactly 1 cycle after fifo_ren.
- to_the_user  output  DATA_W  head-of-buffer data.
- out_valid  output  1  to_the_user holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- busy  output  1  FSM not in IDLE.
- proto_err  output  1  sticky flag: fifo_rvalid arrived with no read outstanding.

Behaviour:
- Reset (rst=0 at a clock edge):
  - to_the_user=0, out_valid=0, busy=0, proto_err=0.
  - Occupancy cnt=0, inflight=0, state=IDLE.
  - fifo_ren=0 while rst=0.
- Internal state:
  - cnt: 0..2 buffered words.
  - inflight: 1 when fifo_ren was asserted the previous cycle.
  - pop = out_valid & out_ready.
- Read issue: fifo_ren = (state==RUN) & ~fifo_empty & ((cnt + inflight - pop) < 2).
  - The credit check counts a same-cycle pop, giving full throughput.
  - Skid overflow is impossible by construction.
- Capture: on fifo_rvalid & inflight, the word is written at tail.
  - cnt_next = cnt + capture - pop.
  - capture and pop in the same cycle with cnt=1: cnt stays 1 and the new word becomes head next cycle.
  - capture with cnt=0: to_the_user updates and out_valid=1 on the next edge. Latency from fifo_ren to out_valid is 2 cycles.
- Output ordering: strictly FIFO order.
  - to_the_user stays stable while out_valid=1 & out_ready=0.
  - out_valid never drops without a pop.
- FSM states IDLE, RUN, STOP:
  - IDLE -> RUN: en=1.
  - RUN -> STOP: en=0.
  - STOP -> RUN: en=1.
  - STOP -> IDLE: en=0 & inflight=0 & cnt=0, after all in-flight and buffered words are delivered.
  - busy = state!=IDLE.
- Empty FIFO in RUN: fifo_ren=0; state stays RUN.
- fifo_empty rising in the same cycle as a read: that read was issued against the pre-empty view and its data is still captured.
- en deasserted with a read in flight: no new reads; the in-flight word is captured and delivered.
- Spurious fifo_rvalid (inflight=0): data ignored, proto_err sets and holds until reset.
- Reset mid-operation: buffered words are discarded. The FIFO must be reset in the same cycle; words in flight are lost.

Optional Feature:
- Macro FIFO_RD_CNT_EN.
- Defined:
  - Adds output rd_count [15:0], a count of words delivered (pop events).
  - Reset to 0; increments by 1 per pop.
  - Wraps 16'hFFFF -> 0.
  - Holds its value through IDLE.
- Not defined: port absent, no counter logic; all other behaviour is identical.

Test Plan:
- Reset with FIFO preloaded with 0x11,0x22,0x33, en=0 -> fifo_ren=0, out_valid=0, busy=0 for all cycles.
- FIFO holds 0x11,0x22,0x33, en=1, out_ready=1 -> fifo_ren high 3 consecutive cycles, out_valid first high 2 cycles after first fifo_ren, outputs 0x11,0x22,0x33 on consecutive cycles.
- Same preload, out_ready=0 -> exactly 2 reads issued, cnt=2, to_the_user=0x11 held stable. Then out_ready=1 -> 0x11,0x22,0x33 in order, none lost or duplicated.
- en dropped the cycle after the first fifo_ren with 4 words queued -> only words already read are delivered, then busy falls; FIFO retains the rest.
- fifo_rvalid pulsed with no preceding fifo_ren -> proto_err=1 and stays 1; no word appears on to_the_user.
- With FIFO_RD_CNT_EN, rd_count preset near wrap by delivering 65538 words -> rd_count reads 2 after wrap; rd_count=0 immediately after reset.
